// File: rtl/arm_core_seq.sv
// Handshaked FETCH/DECODE/MEM sequencer: owns pc, latches inst_q for decode, sequences data accesses.
// FETCH and MEM stall until their ack (optional MAX_WAIT timeout); DECODE is one cycle; CPI 2 ALU / 3 memory.
module arm_core_seq #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                CNT_W        = 32,
  parameter int                MAX_WAIT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic [31:0]       inst_rdata,
  output logic [31:0]       inst_q,
  input  logic              cond_pass,
  input  logic              dec_mem,
  input  logic              dec_store,
  input  logic              dec_branch,
  input  logic              dec_halt,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic              mem_write_en,
  input  logic              mem_ack,
  output logic              exec_en,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  // Three-bit encoding leaves spare codes so a corrupted state can be steered back to FETCH.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_HALT   = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_t;

  state_t            state;
  state_t            state_nxt;
  pc_sel_t           pc_sel;
  logic              retire;
  logic              set_halt;
  logic              set_fault;
  logic              load_inst;
  logic              load_store;
  logic              store_q;
  logic              wait_expired;
  logic              waiting;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] branch_pc;
  logic [1:0]        unused_target_lsb;

  assign branch_pc         = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_target_lsb = branch_target[1:0];
  assign inst_addr         = pc;

  assign wait_expired = (MAX_WAIT > 0) && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
  assign waiting      = ((state == S_FETCH) && !inst_ack) || ((state == S_MEM) && !mem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_sel     = PC_HOLD;
    retire     = 1'b0;
    set_halt   = 1'b0;
    set_fault  = 1'b0;
    load_inst  = 1'b0;
    load_store = 1'b0;
    case (state)
      S_FETCH: begin
        if (inst_ack) begin
          state_nxt = S_DECODE;
          load_inst = 1'b1;
        end else if (wait_expired) begin
          state_nxt = S_HALT;
          set_halt  = 1'b1;
          set_fault = 1'b1;
        end
      end
      S_DECODE: begin
        if (!cond_pass) begin
          state_nxt = S_FETCH;
          pc_sel    = PC_INC;
          retire    = 1'b1;
        end else if (dec_halt) begin
          state_nxt = S_HALT;
          retire    = 1'b1;
          set_halt  = 1'b1;
        end else if (dec_mem) begin
          state_nxt  = S_MEM;
          load_store = 1'b1;
        end else begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
          pc_sel    = dec_branch ? PC_BRANCH : PC_INC;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_nxt = S_FETCH;
          pc_sel    = PC_INC;
          retire    = 1'b1;
        end else if (wait_expired) begin
          state_nxt = S_HALT;
          set_halt  = 1'b1;
          set_fault = 1'b1;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  always_comb begin
    inst_req     = (state == S_FETCH);
    mem_req      = (state == S_MEM);
    mem_write_en = (state == S_MEM) && store_q;
    exec_en      = ((state == S_DECODE) && cond_pass && !dec_halt && !dec_mem) ||
                   ((state == S_MEM) && mem_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      inst_q   <= '0;
      store_q  <= 1'b0;
      retired  <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (pc_sel)
        PC_INC:    pc <= pc + ADDR_W'(4);
        PC_BRANCH: pc <= branch_pc;
        default:   pc <= pc;
      endcase
      if (load_inst) begin
        inst_q <= inst_rdata;
      end
      if (load_store) begin
        store_q <= dec_store;
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
      if (set_halt) begin
        halted <= 1'b1;
      end
      if (set_fault) begin
        fault <= 1'b1;
      end
      // Counter restarts on every state change so each FETCH/MEM visit gets a full budget.
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_arm_core_seq.sv
module tb_arm_core_seq;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] inst_q;
  logic        cond_pass;
  logic        dec_mem;
  logic        dec_store;
  logic        dec_branch;
  logic        dec_halt;
  logic [31:0] branch_target;
  logic        mem_req;
  logic        mem_write_en;
  logic        mem_ack;
  logic        exec_en;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  arm_core_seq #(
    .ADDR_W(32),
    .RESET_VECTOR(32'h100),
    .CNT_W(32),
    .MAX_WAIT(5)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .inst_q(inst_q),
    .cond_pass(cond_pass), .dec_mem(dec_mem), .dec_store(dec_store),
    .dec_branch(dec_branch), .dec_halt(dec_halt), .branch_target(branch_target),
    .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_ack(mem_ack),
    .exec_en(exec_en), .pc(pc), .halted(halted), .fault(fault), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        c;
    logic        br;
    logic        m;
    logic        st;
    logic        hlt;
    logic [31:0] tgt;
    int          fdly;
    int          mdly;
    logic [31:0] exp_addr;
    logic        exp_exec;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_ack      = 1'b0;
    inst_rdata    = '0;
    cond_pass     = 1'b0;
    dec_mem       = 1'b0;
    dec_store     = 1'b0;
    dec_branch    = 1'b0;
    dec_halt      = 1'b0;
    branch_target = '0;
    mem_ack       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    @(negedge clk);
    chk("rst_inst_req", 32'(inst_req), 32'd1);
    chk("rst_pc", pc, 32'h100);
    chk("rst_inst_addr", inst_addr, 32'h100);
    chk("rst_inst_q", inst_q, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_exec_en", 32'(exec_en), 32'd0);
    next_cycle();
    rst = 1'b0;
  endtask

  // One instruction from the first FETCH cycle through commit; returns with the DUT back in FETCH/HALT.
  task automatic run_instr(input logic c, input logic br, input logic m, input logic st,
                           input logic hlt, input logic [31:0] tgt, input int fdly,
                           input int mdly, input logic [31:0] exp_addr,
                           input logic exp_exec, input logic [31:0] exp_ret);
    logic [31:0] w;
    logic go_mem;
    w = $urandom;
    go_mem = c && !hlt && m;
    for (int i = 0; i < fdly; i++) begin
      inst_ack = 1'b0;
      @(negedge clk);
      chk("fetch_wait_req", 32'(inst_req), 32'd1);
      chk("fetch_wait_addr", inst_addr, exp_addr);
      chk("fetch_wait_exec", 32'(exec_en), 32'd0);
      next_cycle();
    end
    inst_ack   = 1'b1;
    inst_rdata = w;
    @(negedge clk);
    chk("fetch_req", 32'(inst_req), 32'd1);
    chk("fetch_addr", inst_addr, exp_addr);
    chk("fetch_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    inst_ack      = 1'b0;
    cond_pass     = c;
    dec_branch    = br;
    dec_mem       = m;
    dec_store     = st;
    dec_halt      = hlt;
    branch_target = tgt;
    @(negedge clk);
    chk("decode_inst_q", inst_q, w);
    chk("decode_inst_req", 32'(inst_req), 32'd0);
    chk("decode_exec", 32'(exec_en), go_mem ? 32'd0 : 32'(exp_exec));
    next_cycle();
    cond_pass = 1'b0; dec_branch = 1'b0; dec_mem = 1'b0;
    dec_store = 1'b0; dec_halt = 1'b0; branch_target = $urandom;
    if (go_mem) begin
      for (int i = 0; i < mdly; i++) begin
        mem_ack = 1'b0;
        @(negedge clk);
        chk("mem_wait_req", 32'(mem_req), 32'd1);
        chk("mem_wait_we", 32'(mem_write_en), 32'(st));
        chk("mem_wait_exec", 32'(exec_en), 32'd0);
        next_cycle();
      end
      mem_ack = 1'b1;
      @(negedge clk);
      chk("mem_ack_req", 32'(mem_req), 32'd1);
      chk("mem_ack_we", 32'(mem_write_en), 32'(st));
      chk("mem_ack_exec", 32'(exec_en), 32'(exp_exec));
      next_cycle();
      mem_ack = 1'b0;
    end
    chk("retired", retired, exp_ret);
  endtask

  initial begin
    logic [31:0] pc_m;
    logic [31:0] ret_m;
    logic c, br, m, st;
    logic [31:0] tgt;

    //           c  br m  st h  tgt          fd md addr        ex ret
    tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h100, 1, 32'd1};
    tbl[1]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h104, 1, 32'd2};
    tbl[2]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h108, 1, 32'd3};
    tbl[3]  = '{1, 0, 0, 0, 0, 32'h0,       0, 0, 32'h10C, 1, 32'd4};
    tbl[4]  = '{1, 1, 0, 0, 0, 32'h13,      0, 0, 32'h110, 1, 32'd5};
    tbl[5]  = '{1, 1, 0, 0, 0, 32'h203,     0, 0, 32'h010, 1, 32'd6};
    tbl[6]  = '{1, 1, 0, 0, 0, 32'h20,      1, 0, 32'h200, 1, 32'd7};
    tbl[7]  = '{0, 1, 0, 0, 0, 32'h400,     0, 0, 32'h020, 0, 32'd8};
    tbl[8]  = '{1, 0, 1, 1, 0, 32'h0,       0, 3, 32'h024, 1, 32'd9};
    tbl[9]  = '{1, 0, 1, 0, 0, 32'h0,       2, 4, 32'h028, 1, 32'd10};
    tbl[10] = '{0, 0, 0, 0, 1, 32'h0,       0, 0, 32'h02C, 0, 32'd11};
    tbl[11] = '{1, 0, 0, 1, 0, 32'h0,       4, 0, 32'h030, 1, 32'd12};
    tbl[12] = '{1, 1, 1, 1, 0, 32'h800,     0, 0, 32'h034, 1, 32'd13};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      run_instr(tbl[i].c, tbl[i].br, tbl[i].m, tbl[i].st, tbl[i].hlt, tbl[i].tgt,
                tbl[i].fdly, tbl[i].mdly, tbl[i].exp_addr, tbl[i].exp_exec, tbl[i].exp_ret);
    end

    // Fetch timeout: five unacked FETCH cycles at 0x38, then fault.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("to_inst_req", 32'(inst_req), 32'd1);
      chk("to_not_halted", 32'(halted), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_inst_req_low", 32'(inst_req), 32'd0);
    chk("to_pc", pc, 32'h38);
    chk("to_retired", retired, 32'd13);

    // Reset abandons an in-flight MEM access; a late mem_ack is ignored.
    do_reset();
    run_instr(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h100, 1, 32'd1);
    inst_ack = 1'b1;
    next_cycle();
    inst_ack = 1'b0; cond_pass = 1'b1; dec_mem = 1'b1; dec_store = 1'b1;
    next_cycle();
    cond_pass = 1'b0; dec_mem = 1'b0; dec_store = 1'b0;
    @(negedge clk);
    chk("rm_mem_req", 32'(mem_req), 32'd1);
    chk("rm_we", 32'(mem_write_en), 32'd1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rm_late_mem_req", 32'(mem_req), 32'd0);
    chk("rm_late_exec", 32'(exec_en), 32'd0);
    chk("rm_late_inst_req", 32'(inst_req), 32'd1);
    chk("rm_late_pc", pc, 32'h100);
    next_cycle();
    mem_ack = 1'b0;
    chk("rm_after_pc", pc, 32'h100);
    chk("rm_after_retired", retired, 32'd0);

    // Halt instruction: retires, pc holds, stays halted until reset.
    run_instr(1, 0, 0, 0, 1, 32'h0, 0, 0, 32'h100, 0, 32'd1);
    inst_ack = 1'b1; mem_ack = 1'b1; cond_pass = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_fault", 32'(fault), 32'd0);
      chk("halt_inst_req", 32'(inst_req), 32'd0);
      chk("halt_mem_req", 32'(mem_req), 32'd0);
      chk("halt_exec", 32'(exec_en), 32'd0);
      chk("halt_pc", pc, 32'h100);
      chk("halt_retired", retired, 32'd1);
      next_cycle();
    end

    // Randomized run against an instruction-level model of pc and retire count.
    do_reset();
    pc_m  = 32'h100;
    ret_m = 32'd0;
    for (int n = 0; n < 300; n++) begin
      c   = ($urandom_range(0, 3) != 0);
      br  = $urandom_range(0, 1) == 1;
      m   = $urandom_range(0, 2) == 0;
      st  = $urandom_range(0, 1) == 1;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      run_instr(c, br, m, st, 1'b0, tgt, $urandom_range(0, 4), $urandom_range(0, 4),
                pc_m, c, ret_m + 32'd1);
      ret_m = ret_m + 32'd1;
      if (c && br && !m) pc_m = tgt & 32'hFFFF_FFFC;
      else               pc_m = pc_m + 32'd4;
    end
    @(negedge clk);
    chk("rand_final_pc", pc, pc_m);
    chk("rand_final_retired", retired, ret_m);
    chk("rand_no_fault", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
